sample_fifo: RTL and testbench

SAMPLE_FIFO -- requirements
Module: sample_fifo

---
 rtl/adc_frontend_pkg.sv | 20 ++
 rtl/sample_fifo_if.sv | 32 +++
 rtl/sample_fifo_mem.sv | 26 ++
 rtl/sample_fifo.sv | 114 +++++++++++
 tb/tb_sample_fifo.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/adc_frontend_pkg.sv
// Shared ADC front-end definitions: lane count default and the width helpers
// that every block in the capture path derives its buses from.
package adc_frontend_pkg;

    localparam int LANES_DEFAULT = 8;

    // Each lane delivers two bits per sample (DDR), so a word is twice the lane count.
    function automatic int word_width(input int lanes);
        return 2 * lanes;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_fifo_if.sv
// Handshake bundle between the word assembler / consumer and the sample FIFO.
interface sample_fifo_if
    import adc_frontend_pkg::*;
#(
    parameter int LANES = LANES_DEFAULT,
    parameter int DEPTH = 16
);
    localparam int W  = word_width(LANES);
    localparam int LW = level_width(DEPTH);

    logic          wr_valid;
    logic [W-1:0]  wr_data;
    logic          stall;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic          rd_ready;
    logic [LW-1:0] level;
    logic [LW-1:0] high_water;
    logic          overflow;
    logic          clr_stats;

    modport slave (
        input  wr_valid, wr_data, rd_ready, clr_stats,
        output stall, rd_valid, rd_data, level, high_water, overflow
    );

    modport master (
        output wr_valid, wr_data, rd_ready, clr_stats,
        input  stall, rd_valid, rd_data, level, high_water, overflow
    );

endinterface

// File: rtl/sample_fifo_mem.sv
// Sample storage: register array with one synchronous write port and one
// asynchronous read port so the head word falls through without a cycle of latency.
module sample_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // Write port; contents are never reset because pointers alone define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sample_fifo.sv
// First-word fall-through sample FIFO between the ADC word assembler and the
// consumer, with registered almost-full stall and occupancy statistics.
module sample_fifo
    import adc_frontend_pkg::*;
#(
    parameter int LANES        = LANES_DEFAULT,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 2
) (
    input  logic          dco_clk,
    input  logic          rst_n,
    sample_fifo_if.slave  bus
);

    localparam int W  = word_width(LANES);
    localparam int LW = level_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [LW-1:0] STALL_LEVEL = LW'(DEPTH - AFULL_MARGIN);

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [LW-1:0] high_water_r;
    logic          stall_r;
    logic          rd_valid_r;
    logic          overflow_r;

    logic          full_s;
    logic          wr_acc_s;
    logic          rd_acc_s;
    logic          ovf_event_s;
    logic [LW-1:0] level_next_s;
    logic [W-1:0]  rd_data_s;

    // Accept decisions use only registered state, so stall is honoured as seen upstream.
    always_comb begin
        full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        wr_acc_s    = bus.wr_valid && !stall_r && !full_s;
        ovf_event_s = bus.wr_valid && !stall_r && full_s;
        rd_acc_s    = rd_valid_r && bus.rd_ready;
    end

    // Post-edge occupancy; a simultaneous read and write leaves it unchanged.
    always_comb begin
        level_next_s = level_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   level_next_s = level_r + LW'(1);
            2'b01:   level_next_s = level_r - LW'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Pointers, occupancy and the registered flags derived from it.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= PW'(0);
            rd_ptr_r   <= PW'(0);
            level_r    <= LW'(0);
            rd_valid_r <= 1'b0;
            stall_r    <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            level_r    <= level_next_s;
            // rd_valid follows the post-edge level, so a word written into an empty FIFO shows up one cycle later.
            rd_valid_r <= (level_next_s != LW'(0));
            stall_r    <= (level_next_s >= STALL_LEVEL);
        end
    end

    // Statistics; a clear wins over a same-edge overflow event.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            high_water_r <= LW'(0);
            overflow_r   <= 1'b0;
        end else if (bus.clr_stats) begin
            high_water_r <= level_next_s;
            overflow_r   <= 1'b0;
        end else begin
            if (level_next_s > high_water_r) begin
                high_water_r <= level_next_s;
            end
            if (ovf_event_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    sample_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_mem (
        .clk   (dco_clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (rd_data_s)
    );

    assign bus.stall      = stall_r;
    assign bus.rd_valid   = rd_valid_r;
    assign bus.rd_data    = rd_data_s;
    assign bus.level      = level_r;
    assign bus.high_water = high_water_r;
    assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_sample_fifo.sv
// Directed and random stimulus for sample_fifo, checked against a queue-based
// model of occupancy, ordering, stall and statistics.
module tb_sample_fifo;

    localparam int LANES  = 8;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;
    localparam int W      = 2 * LANES;

    logic dco_clk = 1'b0;
    logic rst_n   = 1'b0;

    sample_fifo_if #(.LANES(LANES), .DEPTH(DEPTH)) bus ();

    sample_fifo #(
        .LANES        (LANES),
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (MARGIN)
    ) dut (
        .dco_clk (dco_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 dco_clk = ~dco_clk;

    logic [W-1:0] q[$];
    int           m_hw;
    bit           m_stall;
    bit           m_ovf;
    bit           last_wa;
    int           seen_f;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_hw    = 0;
        m_stall = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One clock: check pre-edge outputs, advance the model, check post-edge outputs.
    task automatic cycle();
        bit wa, ra, ovf_ev, clr;
        int lvl;
        chk("rd_valid", bus.rd_valid, 32'(q.size() > 0));
        if (q.size() > 0) chk("rd_data", bus.rd_data, q[0]);
        chk("stall", bus.stall, m_stall);
        wa     = bus.wr_valid && !m_stall && (q.size() < DEPTH);
        ovf_ev = bus.wr_valid && !m_stall && (q.size() == DEPTH);
        ra     = bus.rd_ready && (q.size() > 0);
        clr    = bus.clr_stats;
        if (ra && q[0] == 16'h000F) seen_f++;
        @(posedge dco_clk);
        #1;
        if (ra) void'(q.pop_front());
        if (wa) q.push_back(bus.wr_data);
        lvl     = q.size();
        m_stall = (lvl >= DEPTH - MARGIN);
        if (clr) begin
            m_hw  = lvl;
            m_ovf = 1'b0;
        end else begin
            if (lvl > m_hw) m_hw = lvl;
            if (ovf_ev) m_ovf = 1'b1;
        end
        chk("level", bus.level, lvl);
        chk("high_water", bus.high_water, m_hw);
        chk("overflow", bus.overflow, m_ovf);
        last_wa = wa;
    endtask

    task automatic reset_mid_cycle(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_stall"}, bus.stall, 0);
        chk({tag, "_rd_valid"}, bus.rd_valid, 0);
        chk({tag, "_level"}, bus.level, 0);
        chk({tag, "_high_water"}, bus.high_water, 0);
        chk({tag, "_overflow"}, bus.overflow, 0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] next_word;
        logic [W-1:0] rnd_word;

        bus.wr_valid  = 1'b0;
        bus.wr_data   = 16'h0000;
        bus.rd_ready  = 1'b0;
        bus.clr_stats = 1'b0;
        seen_f        = 0;
        model_reset();
        #12 rst_n = 1'b1;

        // Reset asserted mid-cycle after a few writes, checked without a clock edge.
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_data = 16'h0100 + 16'(i);
            cycle();
        end
        bus.wr_valid = 1'b0;
        reset_mid_cycle("rst_async");

        // Fill with the consumer idle until stall asserts.
        next_word    = 16'h0001;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 40 && next_word <= 16'h000E; i++) begin
            bus.wr_data = next_word;
            cycle();
            if (last_wa) next_word = next_word + 16'h0001;
        end
        chk("fill_stall", bus.stall, 1);
        chk("fill_level", bus.level, 14);
        chk("fill_high_water", bus.high_water, 14);
        bus.wr_data = next_word;
        for (int i = 0; i < 4; i++) cycle();
        chk("fill_ignored_level", bus.level, 14);

        // Drain while the assembler keeps offering its held word.
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (last_wa) bus.wr_valid = 1'b0;
        end
        chk("drain_held_once", seen_f, 1);
        chk("drain_level", bus.level, 0);

        // Steady state at level 5 with a read and a write every cycle.
        bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.wr_data = W'($urandom);
            cycle();
        end
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.wr_data = W'($urandom);
            cycle();
            chk("simul_level", bus.level, 5);
        end
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        chk("simul_drained", bus.level, 0);

        // Write into an empty FIFO with the consumer ready: no bypass.
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'h00AA;
        bus.rd_ready = 1'b1;
        chk("empty_rd_valid_same", bus.rd_valid, 0);
        cycle();
        bus.wr_valid = 1'b0;
        chk("empty_rd_valid_next", bus.rd_valid, 1);
        chk("empty_rd_data_next", bus.rd_data, 16'h00AA);
        cycle();

        // Random traffic with an assembler that holds its word while stalled.
        rnd_word = W'($urandom);
        for (int i = 0; i < 400; i++) begin
            bus.wr_valid  = ($urandom_range(0, 3) != 0);
            bus.wr_data   = rnd_word;
            bus.rd_ready  = ($urandom_range(0, 2) == 0);
            bus.clr_stats = ($urandom_range(0, 19) == 0);
            cycle();
            if (last_wa) rnd_word = W'($urandom);
        end
        bus.clr_stats = 1'b0;

        // Drop the contents at level 9, then clear statistics at level 3.
        bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            bus.rd_ready = 1'b1;
            cycle();
        end
        bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.wr_data = W'($urandom);
            cycle();
        end
        bus.wr_valid = 1'b0;
        chk("pre_reset_level", bus.level, 9);
        reset_mid_cycle("rst_level9");
        cycle();
        chk("post_reset_rd_valid", bus.rd_valid, 0);
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_data = W'($urandom);
            cycle();
        end
        bus.wr_valid  = 1'b0;
        bus.clr_stats = 1'b1;
        cycle();
        bus.clr_stats = 1'b0;
        chk("clr_high_water", bus.high_water, 3);
        chk("clr_overflow", bus.overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
